aes_encipher_block: RTL

Iterative AES encryption datapath for 128-bit and 256-bit keys. It sits directly downstream of the key schedule. It drives the round index, reads the matching 128-bit round key back combinationally, and performs one cipher round per five cycles. SubBytes goes through a single shared 32-bit S-box port, one word per cycle; the core top level muxes that port between this block and the key schedule.

---
 rtl/aes_encipher_block.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath (AES-128 / AES-256).
// One cipher round takes five cycles: four SubBytes cycles through a shared
// 32-bit S-box port, then one ShiftRows/MixColumns/AddRoundKey cycle.
// Handshake: next is sampled only while idle (ready = 1); ready drops on the
// accepting edge and rises again when new_block holds the finished ciphertext.
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_SBOX  = 2'd2;
    localparam logic [1:0] ST_ROUND = 2'd3;

    logic [127:0] state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   word_ctr_q, word_ctr_d;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   num_rounds;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; row = i % 4, column = i / 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    assign num_rounds = keylen_q ? 4'd14 : 4'd10;

    // S-box port always shows the state word picked by word_ctr.
    always_comb begin
        sboxw = state_q[127:96];
        case (word_ctr_q)
            2'd0: sboxw = state_q[127:96];
            2'd1: sboxw = state_q[95:64];
            2'd2: sboxw = state_q[63:32];
            2'd3: sboxw = state_q[31:0];
            default: sboxw = state_q[127:96];
        endcase
    end

    // Next-state logic for the round FSM and the datapath registers.
    always_comb begin
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        word_ctr_d  = word_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        fsm_d       = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (next) begin
                    keylen_d    = keylen;
                    ready_d     = 1'b0;
                    round_ctr_d = 4'd0;
                    fsm_d       = ST_INIT;
                end
            end
            ST_INIT: begin
                // Initial AddRoundKey with round key 0.
                state_d     = block ^ round_key;
                round_ctr_d = 4'd1;
                word_ctr_d  = 2'd0;
                fsm_d       = ST_SBOX;
            end
            ST_SBOX: begin
                case (word_ctr_q)
                    2'd0: state_d[127:96] = new_sboxw;
                    2'd1: state_d[95:64]  = new_sboxw;
                    2'd2: state_d[63:32]  = new_sboxw;
                    2'd3: state_d[31:0]   = new_sboxw;
                    default: state_d = state_q;
                endcase
                word_ctr_d = word_ctr_q + 2'd1;
                if (word_ctr_q == 2'd3) begin
                    fsm_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_ctr_q < num_rounds) begin
                    state_d     = mix_columns(shift_rows(state_q)) ^ round_key;
                    round_ctr_d = round_ctr_q + 4'd1;
                    fsm_d       = ST_SBOX;
                end else begin
                    // Final round skips MixColumns; round_ctr keeps its value.
                    state_d = shift_rows(state_q) ^ round_key;
                    ready_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= '0;
            round_ctr_q <= 4'd0;
            word_ctr_q  <= 2'd0;
            keylen_q    <= 1'b0;
            ready_q     <= 1'b1;
            fsm_q       <= ST_IDLE;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            word_ctr_q  <= word_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
            fsm_q       <= fsm_d;
        end
    end

    assign round     = round_ctr_q;
    assign new_block = state_q;
    assign ready     = ready_q;

endmodule
